// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the CPU run controller.
// Holds the FSM state encoding and the datapath widths used by its ports.
package cpu_ctrl_pkg;

    localparam int PC_W   = 7;
    localparam int DATA_W = 32;
    localparam int RA_W   = 5;
    localparam int CNT_W  = 16;
    localparam int DISP_W = 16;

    typedef enum logic [1:0] {
        PAUSE = 2'd0,
        RUN   = 2'd1,
        STEP  = 2'd2,
        HALT  = 2'd3
    } run_state_t;

endpackage

// File: rtl/cpu_run_controller_edge.sv
// Rising-edge detector for a level input (single-step button).
// Ports: clk, reset (sync, active-high), level in, rise out (one clk wide).
module edge_detect_rise (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic level_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/cpu_run_controller.sv
// Single-clock run/step/pause sequencer issuing one-clk datapath enables.
// Ports: clk, reset (sync, active-high), tick, switch_run, step_btn,
//   switch_select, instr_rs, reg_write_in, pc, rf_read_data_1 in;
//   cpu_en, rf_read_addr_1, rf_write_en, display_value, retired, state_o out.
// Optional: define CPU_RUN_CTRL_BREAKPOINT_EN to add bp_addr/bp_valid ports
//   and the HALT-on-breakpoint behaviour in RUN.
module cpu_run_controller
    import cpu_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              switch_run,
    input  logic              step_btn,
    input  logic [RA_W-1:0]   switch_select,
    input  logic [RA_W-1:0]   instr_rs,
    input  logic              reg_write_in,
    input  logic [PC_W-1:0]   pc,
    input  logic [DATA_W-1:0] rf_read_data_1,
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    input  logic [PC_W-1:0]   bp_addr,
    input  logic              bp_valid,
`endif
    output logic              cpu_en,
    output logic [RA_W-1:0]   rf_read_addr_1,
    output logic              rf_write_en,
    output logic [DISP_W-1:0] display_value,
    output logic [CNT_W-1:0]  retired,
    output logic [1:0]        state_o
);

    run_state_t state, state_n;
    logic       en_n;
    logic       step_rise;
    logic       bp_hit;
    logic       executing;

    // Upper data bits never reach the 4-digit display.
    logic unused_rf_bits;
    assign unused_rf_bits = ^rf_read_data_1[DATA_W-1:DISP_W];

    edge_detect_rise u_step_edge (
        .clk   (clk),
        .reset (reset),
        .level (step_btn),
        .rise  (step_rise)
    );

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    assign bp_hit = bp_valid && (pc == bp_addr);
`else
    assign bp_hit = 1'b0;
`endif

    always_comb begin
        state_n = state;
        en_n    = 1'b0;
        unique case (state)
            PAUSE: begin
                if (switch_run) begin
                    state_n = RUN;
                end else if (step_rise) begin
                    state_n = STEP;
                    en_n    = 1'b1;
                end
            end
            RUN: begin
                // A tick arriving with the run switch already low is dropped.
                if (!switch_run) begin
                    state_n = PAUSE;
                end else if (tick) begin
                    if (bp_hit) begin
                        state_n = HALT;
                    end else begin
                        en_n = 1'b1;
                    end
                end
            end
            STEP: begin
                state_n = PAUSE;
            end
            HALT: begin
                if (!switch_run) begin
                    state_n = PAUSE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= PAUSE;
            cpu_en        <= 1'b0;
            retired       <= '0;
            display_value <= '0;
        end else begin
            state  <= state_n;
            cpu_en <= en_n;
            if (cpu_en) begin
                retired <= retired + 1'b1;
            end
            if (state == PAUSE) begin
                display_value <= rf_read_data_1[DISP_W-1:0];
            end else begin
                display_value <= {{(DISP_W-PC_W){1'b0}}, pc};
            end
        end
    end

    assign executing      = (state == RUN) || (state == STEP);
    assign rf_read_addr_1 = executing ? instr_rs : switch_select;
    assign rf_write_en    = reg_write_in & cpu_en & executing;
    assign state_o        = state;

endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
Sequencing controller for the single-cycle processor. It replaces ad-hoc clock muxing with a single-clock FSM that issues one-cycle datapath enables (cpu_en) for run, single-step and pause. While paused it owns register-file port 1 for inspection and blocks register-file writes. It selects the 16-bit value shown on the 4-digit SSD and keeps a retired-instruction counter. It sits between the clock divider/switches and the PC, register file and data memory enable inputs.

Parameters:
PC_W, 7, program counter width
DATA_W, 32, register-file data width
RA_W, 5, register address width
CNT_W, 16, retired-instruction counter width

Ports:
clk  in  1  system clock; all datapath state advances only on clk edges where cpu_en=1
reset  in  1  synchronous, active-high
tick  in  1  one-clk-wide run-rate strobe (1 Hz equivalent) from divider
switch_run  in  1  1=run, 0=pause/inspect (pre-synchronised)
step_btn  in  1  debounced single-step button, level
switch_select  in  RA_W  register to inspect while paused
instr_rs  in  RA_W  instruction[25:21]
reg_write_in  in  1  reg_write from control decoder
pc  in  PC_W  current PC
rf_read_data_1  in  DATA_W  register-file port-1 data
cpu_en  out  1  one-clk enable for PC, reg-file write, D-MEM write
rf_read_addr_1  out  RA_W  port-1 address
rf_write_en  out  1  gated register-file write enable
display_value  out  16  value for SSD digits
retired  out  CNT_W  count of cpu_en pulses
state_o  out  2  encoded FSM state (for LED)

Behaviour:
- States: PAUSE=0, RUN=1, STEP=2, HALT=3. Reset → PAUSE. All outputs registered except rf_read_addr_1 and rf_write_en, which are combinational from the state register.
- Reset values: cpu_en=0, retired=0, display_value=0, state_o=0.
- step_rise = step_btn & ~step_q; step_q is a register, reset 0.
- PAUSE: switch_run=1 → RUN. Otherwise, step_rise → STEP. switch_run has priority over step_rise.
- STEP: exactly one clk cycle long. cpu_en=1 in this cycle, then PAUSE unconditionally. Holding step_btn issues no further steps; a new rising edge is required.
- RUN: cpu_en = tick in the same state cycle, registered one clk later. switch_run=0 → PAUSE. A tick coinciding with switch_run=0 is dropped: no pulse.
- HALT: reachable only with the optional feature. cpu_en=0. switch_run=0 → PAUSE.
- Latency: step_btn rises at cycle n → STEP and cpu_en=1 at n+1 → PAUSE at n+2.
- rf_read_addr_1 = instr_rs in RUN/STEP; switch_select in PAUSE/HALT.
- rf_write_en = reg_write_in & cpu_en. It is never high in PAUSE or HALT.
- display_value, registered each clk:
  - RUN/STEP/HALT: zero-extended pc.
  - PAUSE: rf_read_data_1[15:0].
- retired increments on every cycle with cpu_en=1 and wraps at 2^CNT_W−1 → 0.
- Reset mid-STEP or mid-RUN: state → PAUSE and cpu_en=0 in the following cycle. No partial enable.

Optional Feature:
Macro CPU_RUN_CTRL_BREAKPOINT_EN.
- Defined: adds ports bp_addr (in, PC_W) and bp_valid (in, 1).
  - In RUN, when cpu_en would be issued and pc==bp_addr with bp_valid=1, the pulse is suppressed and the state → HALT. The instruction at bp_addr does not execute.
  - A STEP from PAUSE always executes, even at bp_addr.
- Undefined: no extra ports; HALT is unreachable; state_o never equals 3.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - state encoding constants PAUSE/RUN/STEP/HALT
  - widths PC_W, RA_W, CNT_W
  - DISP_W=16
- One natural sub-module: edge_detect_rise, for the step_btn rising-edge register.
- The FSM, muxes and counter stay in the top.

Test Plan:
- Reset asserted 3 cycles with switch_run=1 → state_o=0, cpu_en=0, retired=0. RUN is entered on the first cycle after reset deasserts.
- switch_run=1, 5 tick strobes 100 clks apart → exactly 5 cpu_en pulses, each 1 clk, lagging tick by 1 clk; retired=5.
- PAUSE, step_btn held high 20 clks → exactly one cpu_en pulse at n+1; state_o sequence 0,2,0.
- PAUSE, switch_select=5'd9, rf_read_data_1=32'hABCD1234 → rf_read_addr_1=9, display_value=16'h1234. rf_write_en=0 even with reg_write_in=1.
- RUN, tick and switch_run falling in the same cycle → no cpu_en pulse; state PAUSE; retired unchanged.
- BREAKPOINT_EN defined, bp_addr=7'd12, bp_valid=1, run from pc=0 → halts with pc=12 and no pulse issued at pc=12. switch_run=0 then a step → one pulse; PC advances past 12.
